shift_add_mac: RTL and testbench

Sequential 8-bit multiply-accumulate unit answering the Load/Done handshake issued by the 3x3 matrix controller, one instance per result element. Each accepted Load multiplies B by C with a shift-add datapath, one multiplier bit per clock, and adds the truncated product into an 8-bit accumulator driven on Aout. Done reports idle/ready to the controller, and a sticky overflow flag reports lost precision.

---
 rtl/shift_add_mac.sv | 108 ++++++++++
 tb/tb_shift_add_mac.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mac.sv
// Sequential shift-add multiply-accumulate: one multiplier bit per clock, truncated product added into Aout.
// Optional macro SHIFT_ADD_MAC_EARLY_EXIT_EN ends the MUL phase once the remaining multiplier bits are zero.
module shift_add_mac #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic             Load,
    input  logic             Clear,
    output logic [WIDTH-1:0] Aout,
    output logic             Done,
    output logic             Ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2
    } state_t;

    state_t               state_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     base_q;
    logic [WIDTH-1:0]     aout_q;
    logic                 ovf_q;
    logic                 done_q;

    logic [2*WIDTH-1:0]   prod_d;
    logic [WIDTH-1:0]     mplier_d;
    logic [WIDTH:0]       sum_d;
    logic                 mul_last;

    always_comb begin
        mplier_d = mplier_q >> 1;
        prod_d   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        sum_d    = {1'b0, base_q} + {1'b0, prod_q[WIDTH-1:0]};
`ifdef SHIFT_ADD_MAC_EARLY_EXIT_EN
        mul_last = (mplier_d == '0) || (cnt_q == CNT_W'(WIDTH - 1));
`else
        mul_last = (cnt_q == CNT_W'(WIDTH - 1));
`endif
    end

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            base_q   <= '0;
            aout_q   <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Load) begin
                        mcand_q  <= {{WIDTH{1'b0}}, B};
                        mplier_q <= C;
                        prod_q   <= '0;
                        cnt_q    <= '0;
                        // Load+Clear together starts from the preload value instead of Aout
                        base_q   <= Clear ? Ain : aout_q;
                        done_q   <= 1'b0;
                        state_q  <= MUL;
                    end else if (Clear) begin
                        aout_q <= Ain;
                        ovf_q  <= 1'b0;
                    end
                end
                MUL: begin
                    prod_q   <= prod_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (mul_last) begin
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    aout_q  <= sum_d[WIDTH-1:0];
                    // Sticky: carry out of the add or any dropped high product bit
                    ovf_q   <= ovf_q | sum_d[WIDTH] | (prod_q[2*WIDTH-1:WIDTH] != '0);
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Aout = aout_q;
    assign Done = done_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_shift_add_mac.sv
// Randomized self-checking bench for shift_add_mac against a plain-arithmetic accumulator model.
module tb_shift_add_mac;

    logic       clk = 1'b0;
    logic       Reset_n;
    logic [7:0] Ain, B, C;
    logic       Load, Clear;
    logic [7:0] Aout;
    logic       Done, Ovf;

    int n_checks = 0;
    int n_pass   = 0;

    int m_acc = 0;
    bit m_ovf = 1'b0;

    shift_add_mac #(.WIDTH(8)) dut (
        .clk(clk), .Reset_n(Reset_n), .Ain(Ain), .B(B), .C(C),
        .Load(Load), .Clear(Clear), .Aout(Aout), .Done(Done), .Ovf(Ovf)
    );

    always #5 clk = ~clk;

    function automatic int exp_low(input logic [7:0] c);
        int n;
        n = 9;
`ifdef SHIFT_ADD_MAC_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < 8; i++) if (c[i]) n = i + 1;
        n = n + 1;
`endif
        return n;
    endfunction

    task automatic model_op(input int b, input int c, input int ain, input bit clr);
        int base, p, sum;
        base  = clr ? ain : m_acc;
        p     = b * c;
        sum   = base + (p % 256);
        m_ovf = m_ovf | (sum > 255) | (p > 255);
        m_acc = sum % 256;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done) break;
            cnt++;
        end
    endtask

    task automatic run_op(input logic [7:0] b, input logic [7:0] c, input logic [7:0] ain,
                          input bit clr, output int cnt);
        @(negedge clk);
        B = b; C = c; Ain = ain; Load = 1'b1; Clear = clr;
        @(posedge clk);
        #1;
        Load = 1'b0; Clear = 1'b0;
        B = 8'($urandom); C = 8'($urandom); Ain = 8'($urandom);
        wait_done(cnt);
        model_op(b, c, ain, clr);
    endtask

    task automatic do_clear(input logic [7:0] ain);
        @(negedge clk);
        Ain = ain; Clear = 1'b1;
        @(posedge clk);
        #1;
        Clear = 1'b0;
        m_acc = ain; m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; Load = 1'b0; Clear = 1'b0; Ain = '0; B = '0; C = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (Aout !== 8'd0 || Ovf !== 1'b0 || Done !== 1'b1)
            $display("FAIL reset: Aout=%0d Ovf=%0b Done=%0b, want 0/0/1", Aout, Ovf, Done);
        else n_pass++;
        Reset_n = 1'b1;
        m_acc = 0; m_ovf = 1'b0;
    endtask

    task automatic test_basic;
        int cnt;
        run_op(8'd3, 8'd5, 8'd0, 1'b0, cnt);
        n_checks++;
        if (cnt !== exp_low(8'd5)) $display("FAIL basic_latency: got %0d want %0d", cnt, exp_low(8'd5));
        else n_pass++;
        n_checks++;
        if (Aout !== 8'd15 || Ovf !== 1'b0) $display("FAIL basic_result: Aout=%0d Ovf=%0b, want 15/0", Aout, Ovf);
        else n_pass++;
    endtask

    task automatic test_wrap_clear;
        int cnt;
        run_op(8'd10, 8'd25, 8'd0, 1'b0, cnt);
        n_checks++;
        if (Aout !== 8'd9 || Ovf !== 1'b1) $display("FAIL wrap: Aout=%0d Ovf=%0b, want 9/1", Aout, Ovf);
        else n_pass++;
        do_clear(8'd7);
        n_checks++;
        if (Aout !== 8'd7 || Ovf !== 1'b0 || Done !== 1'b1)
            $display("FAIL clear: Aout=%0d Ovf=%0b Done=%0b, want 7/0/1", Aout, Ovf, Done);
        else n_pass++;
    endtask

    task automatic test_load_clear;
        int cnt;
        do_clear(8'd100);
        n_checks++;
        if (Aout !== 8'd100) $display("FAIL preload100: Aout=%0d want 100", Aout);
        else n_pass++;
        run_op(8'd2, 8'd6, 8'd4, 1'b1, cnt);
        n_checks++;
        if (Aout !== 8'd16 || Aout !== 8'(m_acc)) $display("FAIL load_clear: Aout=%0d want 16", Aout);
        else n_pass++;
    endtask

    task automatic test_busy_ignore;
        int cnt;
        do_clear(8'd0);
        @(negedge clk);
        B = 8'd2; C = 8'd2; Load = 1'b1;
        @(posedge clk);
        #1 Load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        Load = 1'b1; Clear = 1'b1; B = 8'd255; C = 8'd255; Ain = 8'd55;
        @(posedge clk);
        #1;
        Load = 1'b0; Clear = 1'b0;
        wait_done(cnt);
        model_op(2, 2, 0, 1'b0);
        repeat (12) @(negedge clk);
        n_checks++;
        if (Aout !== 8'd4 || Done !== 1'b1 || Ovf !== m_ovf)
            $display("FAIL busy_ignore: Aout=%0d Done=%0b Ovf=%0b, want 4/1/%0b", Aout, Done, Ovf, m_ovf);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int cnt;
        @(negedge clk);
        B = 8'd7; C = 8'd9; Load = 1'b1;
        @(posedge clk);
        #1 Load = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (Done !== 1'b0) $display("FAIL busy_before_reset: Done=%0b want 0", Done);
        else n_pass++;
        Reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (Aout !== 8'd0 || Ovf !== 1'b0 || Done !== 1'b1)
            $display("FAIL reset_mid: Aout=%0d Ovf=%0b Done=%0b, want 0/0/1", Aout, Ovf, Done);
        else n_pass++;
        Reset_n = 1'b1;
        m_acc = 0; m_ovf = 1'b0;
        run_op(8'd4, 8'd4, 8'd0, 1'b0, cnt);
        n_checks++;
        if (Aout !== 8'd16 || cnt !== exp_low(8'd4))
            $display("FAIL after_reset: Aout=%0d cycles=%0d, want 16/%0d", Aout, cnt, exp_low(8'd4));
        else n_pass++;
    endtask

    task automatic test_early_exit;
        int cnt;
        do_clear(8'd0);
        run_op(8'd9, 8'd1, 8'd0, 1'b0, cnt);
        n_checks++;
        if (cnt !== exp_low(8'd1) || Aout !== 8'd9)
            $display("FAIL exit_c1: cycles=%0d Aout=%0d, want %0d/9", cnt, Aout, exp_low(8'd1));
        else n_pass++;
        run_op(8'd1, 8'h80, 8'd0, 1'b0, cnt);
        n_checks++;
        if (cnt !== 9 || Aout !== 8'd137)
            $display("FAIL exit_c80: cycles=%0d Aout=%0d, want 9/137", cnt, Aout);
        else n_pass++;
        run_op(8'd200, 8'd0, 8'd0, 1'b0, cnt);
        n_checks++;
        if (cnt !== exp_low(8'd0) || Aout !== 8'd137)
            $display("FAIL exit_c0: cycles=%0d Aout=%0d, want %0d/137", cnt, Aout, exp_low(8'd0));
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int cnt;
        logic [7:0] b2, c2;
        @(negedge clk);
        B = 8'd11; C = 8'd13; Load = 1'b1;
        @(posedge clk);
        #1;
        wait_done(cnt);
        model_op(11, 13, 0, 1'b0);
        n_checks++;
        if (cnt !== exp_low(8'd13) || Aout !== 8'(m_acc))
            $display("FAIL b2b_first: cycles=%0d Aout=%0d, want %0d/%0d", cnt, Aout, exp_low(8'd13), m_acc);
        else n_pass++;
        b2 = 8'($urandom); c2 = 8'($urandom);
        B = b2; C = c2;
        @(posedge clk);
        #1 Load = 1'b0;
        wait_done(cnt);
        model_op(b2, c2, 0, 1'b0);
        n_checks++;
        if (cnt !== exp_low(c2) || Aout !== 8'(m_acc) || Ovf !== m_ovf)
            $display("FAIL b2b_second: cycles=%0d Aout=%0d Ovf=%0b, want %0d/%0d/%0b",
                     cnt, Aout, Ovf, exp_low(c2), m_acc, m_ovf);
        else n_pass++;
    endtask

    task automatic test_random;
        int cnt;
        logic [7:0] b, c, a;
        bit clr;
        for (int k = 0; k < 20; k++) begin
            b = 8'($urandom); c = 8'($urandom); a = 8'($urandom);
            if (k % 5 == 0) c = 8'($urandom_range(0, 3));
            clr = ($urandom_range(0, 3) == 0);
            if (k == 7) do_clear(a);
            run_op(b, c, a, clr, cnt);
            n_checks++;
            if (cnt !== exp_low(c) || Aout !== 8'(m_acc) || Ovf !== m_ovf)
                $display("FAIL random_%0d: B=%0d C=%0d clr=%0b cycles=%0d Aout=%0d Ovf=%0b, want %0d/%0d/%0b",
                         k, b, c, clr, cnt, Aout, Ovf, exp_low(c), m_acc, m_ovf);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wrap_clear;
        test_load_clear;
        test_busy_ignore;
        test_reset_mid;
        test_early_exit;
        test_back_to_back;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
